array111_regpx_ctrl: RTL and testbench

Controller in front of one parity-protected 1R1W register-array instance (single clock domain; the array's wclk and rclk are both tied to wclk).
- After reset, or on request, it sequences a full-array initialisation sweep, then clears the array's parity sticky.
- It round-robin arbitrates two write clients onto the single write port.
- It pipelines one read client and tracks the array's parity-error status for CPU/interrupt use.

---
 rtl/array111_regpx_ctrl_pkg.sv | 13 +
 rtl/array111_rr_arb2.sv | 39 +++
 rtl/array111_regpx_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_array111_regpx_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/array111_regpx_ctrl_pkg.sv
// rtl/array111_regpx_ctrl_pkg.sv - shared types and constants for the register-array controller
package array111_regpx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/array111_rr_arb2.sv
// rtl/array111_rr_arb2.sv - two-way round-robin arbiter with last-grant pointer
module array111_rr_arb2 (
    input  logic wclk,
    input  logic rst_,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    // last_b=1 means B was granted most recently, so A wins the next tie
    logic last_b;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (req_a && req_b) begin
                gnt_a = last_b;
                gnt_b = !last_b;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            last_b <= 1'b1;
        end else if (gnt_a) begin
            last_b <= 1'b0;
        end else if (gnt_b) begin
            last_b <= 1'b1;
        end
    end

endmodule

// File: rtl/array111_regpx_ctrl.sv
// rtl/array111_regpx_ctrl.sv - init sweep, write arbitration, read pipeline and parity tracking for one 1R1W array
module array111_regpx_ctrl
    import array111_regpx_ctrl_pkg::*;
#(
    parameter int               ADDRBIT = 9,
    parameter int               DEPTH   = 512,
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] INITVAL = '0,
    parameter int               CLR_CYC = 4
) (
    input  logic                 rst_,
    input  logic                 wclk,
    input  logic                 init_start,
    output logic                 init_done,
    input  logic                 wreq_a,
    input  logic [ADDRBIT-1:0]   waddr_a,
    input  logic [WIDTH-1:0]     wdata_a,
    output logic                 wgnt_a,
    input  logic                 wreq_b,
    input  logic [ADDRBIT-1:0]   waddr_b,
    input  logic [WIDTH-1:0]     wdata_b,
    output logic                 wgnt_b,
    input  logic                 rreq,
    input  logic [ADDRBIT-1:0]   raddr,
    output logic                 rvalid,
    output logic [ADDRBIT-1:0]   mem_wa,
    output logic                 mem_we,
    output logic [WIDTH-1:0]     mem_di,
    output logic [ADDRBIT-1:0]   mem_ra,
    output logic [1:0]           mem_par_ctrl,
    input  logic                 mem_par_err,
    input  logic                 par_clr,
    input  logic                 par_dis,
    output logic                 par_int,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 addr_err
);

    localparam int                 CLR_W     = $clog2(CLR_CYC) + 1;
    localparam logic [ADDRBIT:0]   DEPTH_W   = (ADDRBIT + 1)'(DEPTH);
    localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(DEPTH - 1);
    localparam logic [CLR_W-1:0]   CLR_LAST  = CLR_W'(CLR_CYC - 1);

    state_t             state;
    state_t             state_nxt;
    logic [ADDRBIT-1:0] cnt;
    logic [CLR_W-1:0]   clr_cnt;

    logic run;
    logic sweep;
    logic clr_phase;

    logic a_ok;
    logic b_ok;
    logic r_ok;
    logic rd_issue;
    logic rd_pend;
    logic bad_req;

    logic par_clr_q;
    logic err_prev;
    logic sticky_clr;

    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            state   <= ST_INIT;
            cnt     <= '0;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= (state == ST_INIT && cnt != LAST_ADDR) ? cnt + 1'b1 : '0;
            clr_cnt <= (state == ST_CLR) ? clr_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (cnt == LAST_ADDR)     state_nxt = ST_CLR;
            ST_CLR:  if (clr_cnt == CLR_LAST)  state_nxt = ST_RUN;
            ST_RUN:  if (init_start)           state_nxt = ST_INIT;
            default:                           state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        run       = (state == ST_RUN);
        sweep     = (state == ST_INIT);
        clr_phase = (state == ST_CLR);
        init_done = run;
    end

    array111_rr_arb2 u_arb (
        .wclk  (wclk),
        .rst_  (rst_),
        .en    (run),
        .req_a (wreq_a),
        .req_b (wreq_b),
        .gnt_a (wgnt_a),
        .gnt_b (wgnt_b)
    );

    assign a_ok     = ({1'b0, waddr_a} < DEPTH_W);
    assign b_ok     = ({1'b0, waddr_b} < DEPTH_W);
    assign r_ok     = ({1'b0, raddr}   < DEPTH_W);
    assign rd_issue = run && rreq;
    assign bad_req  = (wgnt_a && !a_ok) || (wgnt_b && !b_ok) || (rd_issue && !r_ok);

    // Out-of-range writes still consume the grant but never reach the array
    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            mem_we <= 1'b0;
            mem_wa <= '0;
            mem_di <= '0;
        end else if (sweep) begin
            mem_we <= 1'b1;
            mem_wa <= cnt;
            mem_di <= INITVAL;
        end else if (wgnt_a) begin
            mem_we <= a_ok;
            mem_wa <= waddr_a;
            mem_di <= wdata_a;
        end else if (wgnt_b) begin
            mem_we <= b_ok;
            mem_wa <= waddr_b;
            mem_di <= wdata_b;
        end else begin
            mem_we <= 1'b0;
        end
    end

    // Second stage of rvalid lines up with the array's output register
    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            mem_ra  <= '0;
            rd_pend <= 1'b0;
            rvalid  <= 1'b0;
        end else begin
            if (rd_issue) begin
                mem_ra <= raddr;
            end
            rd_pend <= rd_issue;
            rvalid  <= rd_pend;
        end
    end

    assign sticky_clr   = clr_phase || par_clr_q;
    assign mem_par_ctrl = {par_dis, sticky_clr};

    // Edge history is dropped while the sticky is being cleared so a fresh error re-fires
    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            par_clr_q <= 1'b0;
            err_prev  <= 1'b0;
            par_int   <= 1'b0;
        end else begin
            par_clr_q <= par_clr;
            err_prev  <= sticky_clr ? 1'b0 : mem_par_err;
            par_int   <= mem_par_err && !err_prev && !sticky_clr;
        end
    end

    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            err_cnt  <= '0;
            addr_err <= 1'b0;
        end else begin
            if (par_clr) begin
                err_cnt <= '0;
            end else if (par_int && err_cnt != ERR_CNT_MAX) begin
                err_cnt <= err_cnt + 1'b1;
            end

            if (par_clr) begin
                addr_err <= 1'b0;
            end else if (bad_req) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_array111_regpx_ctrl.sv
// tb/tb_array111_regpx_ctrl.sv - randomized self-checking bench against a behavioural controller model
module tb_array111_regpx_ctrl;

    localparam int          ADDRBIT = 4;
    localparam int          DEPTH   = 8;
    localparam int          WIDTH   = 32;
    localparam int          CLR_CYC = 4;
    localparam logic [31:0] INITVAL = 32'h1234_5678;

    logic               rst_;
    logic               wclk;
    logic               init_start;
    logic               init_done;
    logic               wreq_a, wreq_b;
    logic [ADDRBIT-1:0] waddr_a, waddr_b;
    logic [WIDTH-1:0]   wdata_a, wdata_b;
    logic               wgnt_a, wgnt_b;
    logic               rreq;
    logic [ADDRBIT-1:0] raddr;
    logic               rvalid;
    logic [ADDRBIT-1:0] mem_wa, mem_ra;
    logic               mem_we;
    logic [WIDTH-1:0]   mem_di;
    logic [1:0]         mem_par_ctrl;
    logic               mem_par_err;
    logic               par_clr, par_dis;
    logic               par_int;
    logic [7:0]         err_cnt;
    logic               addr_err;
    logic [WIDTH-1:0]   mem_do;
    logic [WIDTH-1:0]   arr [16];

    array111_regpx_ctrl #(
        .ADDRBIT (ADDRBIT),
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .INITVAL (INITVAL),
        .CLR_CYC (CLR_CYC)
    ) dut (
        .rst_         (rst_),
        .wclk         (wclk),
        .init_start   (init_start),
        .init_done    (init_done),
        .wreq_a       (wreq_a),
        .waddr_a      (waddr_a),
        .wdata_a      (wdata_a),
        .wgnt_a       (wgnt_a),
        .wreq_b       (wreq_b),
        .waddr_b      (waddr_b),
        .wdata_b      (wdata_b),
        .wgnt_b       (wgnt_b),
        .rreq         (rreq),
        .raddr        (raddr),
        .rvalid       (rvalid),
        .mem_wa       (mem_wa),
        .mem_we       (mem_we),
        .mem_di       (mem_di),
        .mem_ra       (mem_ra),
        .mem_par_ctrl (mem_par_ctrl),
        .mem_par_err  (mem_par_err),
        .par_clr      (par_clr),
        .par_dis      (par_dis),
        .par_int      (par_int),
        .err_cnt      (err_cnt),
        .addr_err     (addr_err)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Array stand-in: registered read, read-before-write on a shared edge
    always @(posedge wclk) begin
        mem_do <= arr[mem_ra];
        if (mem_we) arr[mem_wa] <= mem_di;
    end

    typedef struct {
        int          due;
        bit          chk;
        logic [31:0] data;
    } rd_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] m_mem [16];
    bit          m_run;
    bit          m_last_b;
    bit          m_addr_err;
    bit          last_ga, last_gb;
    rd_t         rq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        cyc++;
        @(negedge wclk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = INITVAL;
        m_last_b   = 1'b1;
        m_addr_err = 1'b0;
        rq.delete();
    endtask

    function automatic logic [ADDRBIT-1:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return ADDRBIT'($urandom_range(DEPTH, 15));
        return ADDRBIT'($urandom_range(0, DEPTH - 1));
    endfunction

    // One clock of traffic: predict grants, write, read return and addr_err from the model
    task automatic run_cycle();
        bit                 ea, eb, bad, exp_we, ev;
        logic [ADDRBIT-1:0] wa;
        logic [31:0]        wd;
        rd_t                r;
        #1;
        ea = 1'b0;
        eb = 1'b0;
        if (m_run) begin
            if (wreq_a && wreq_b) begin
                if (m_last_b) ea = 1'b1; else eb = 1'b1;
            end else begin
                ea = wreq_a;
                eb = wreq_b;
            end
        end
        chk("wgnt_a", 32'(wgnt_a), 32'(ea));
        chk("wgnt_b", 32'(wgnt_b), 32'(eb));
        last_ga = wgnt_a;
        last_gb = wgnt_b;
        bad = 1'b0;
        if (m_run && rreq) begin
            r.due  = cyc + 2;
            r.chk  = (raddr < DEPTH);
            r.data = m_mem[raddr];
            rq.push_back(r);
            if (raddr >= DEPTH) bad = 1'b1;
        end
        exp_we = 1'b0;
        wa     = '0;
        wd     = '0;
        if (ea || eb) begin
            wa       = ea ? waddr_a : waddr_b;
            wd       = ea ? wdata_a : wdata_b;
            m_last_b = eb;
            if (wa < DEPTH) begin
                exp_we    = 1'b1;
                m_mem[wa] = wd;
            end else begin
                bad = 1'b1;
            end
        end
        if (par_clr) m_addr_err = 1'b0;
        else if (bad) m_addr_err = 1'b1;
        step();
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) begin
            chk("mem_wa", 32'(mem_wa), 32'(wa));
            chk("mem_di", mem_di, wd);
        end
        ev = (rq.size() > 0) && (rq[0].due == cyc);
        chk("rvalid", 32'(rvalid), 32'(ev));
        if (ev) begin
            r = rq.pop_front();
            if (r.chk) chk("rdata", mem_do, r.data);
        end
        chk("addr_err", 32'(addr_err), 32'(m_addr_err));
    endtask

    task automatic idle(input int n);
        wreq_a = 0; wreq_b = 0; rreq = 0; par_clr = 0; init_start = 0;
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic wait_run(output int nlow);
        nlow = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (init_done) break;
            chk("sweep_gnt_a", 32'(wgnt_a), 32'd0);
            chk("sweep_gnt_b", 32'(wgnt_b), 32'd0);
            chk("sweep_rvalid", 32'(rvalid), 32'd0);
            nlow++;
            step();
        end
    endtask

    initial begin
        int n_we, n_clr, done_at, npi, nlow;

        rst_ = 0; init_start = 0; wreq_a = 0; wreq_b = 0; rreq = 0; par_clr = 0; par_dis = 0;
        waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0; raddr = '0; mem_par_err = 0;
        m_run = 0;
        model_reset();
        step();
        step();
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_par_ctrl", 32'(mem_par_ctrl), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_misc", {27'd0, rvalid, par_int, addr_err, wgnt_a, wgnt_b}, 32'd0);

        rst_ = 1;
        cyc  = 0;
        rreq = 1;
        raddr = 4'd2;
        n_we = 0; n_clr = 0; done_at = -1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (mem_we) begin
                chk("init_wa", 32'(mem_wa), 32'(n_we));
                chk("init_di", mem_di, INITVAL);
                n_we++;
            end
            if (mem_par_ctrl[0]) n_clr++;
            if (init_done && done_at < 0) done_at = k;
            chk("init_rvalid", 32'(rvalid), 32'd0);
            if (k == 10) rreq = 0;
        end
        chk("init_we_cycles", 32'(n_we), 32'(DEPTH));
        chk("init_clr_cycles", 32'(n_clr), 32'(CLR_CYC));
        chk("init_done_cycle", 32'(done_at), 32'(DEPTH + CLR_CYC));
        m_run = 1;

        // tie: A first after reset, then alternate
        wreq_a = 1; waddr_a = 4'd1; wdata_a = 32'hAAAA_0001;
        wreq_b = 1; waddr_b = 4'd2; wdata_b = 32'hBBBB_0002;
        for (int k = 0; k < 4; k++) begin
            run_cycle();
            chk("tie_order", 32'(last_ga), 32'(k % 2 == 0));
        end
        idle(2);

        wreq_a = 1; waddr_a = 4'd3; wdata_a = 32'h5A5A_5A5A;
        run_cycle();
        wreq_a = 0; rreq = 1; raddr = 4'd3;
        run_cycle();
        rreq = 0;
        run_cycle();
        run_cycle();
        chk("readback_valid", 32'(rvalid), 32'd0);

        // same-cycle write and read of one address returns old contents
        wreq_b = 1; waddr_b = 4'd5; wdata_b = 32'hDEAD_BEEF; rreq = 1; raddr = 4'd5;
        run_cycle();
        wreq_b = 0; rreq = 0;
        run_cycle();
        chk("raw_old_data", mem_do, INITVAL);
        idle(2);

        par_dis = 1;
        #1 chk("par_dis", 32'(mem_par_ctrl[1]), 32'd1);
        par_dis = 0;

        mem_par_err = 1; npi = 0;
        for (int k = 0; k < 5; k++) begin run_cycle(); npi += int'(par_int); end
        chk("par_int_once", 32'(npi), 32'd1);
        chk("err_cnt_one", 32'(err_cnt), 32'd1);
        par_clr = 1;
        run_cycle();
        par_clr = 0;
        chk("err_cnt_cleared", 32'(err_cnt), 32'd0);
        chk("clr_pulse", 32'(mem_par_ctrl[0]), 32'd1);
        mem_par_err = 0;
        n_clr = 1; npi = 0;
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            n_clr += int'(mem_par_ctrl[0]);
            npi += int'(par_int);
        end
        chk("clr_pulse_len", 32'(n_clr), 32'd1);
        chk("no_refire", 32'(npi), 32'd0);

        mem_par_err = 1;
        run_cycle();
        chk("par_int_edge", 32'(par_int), 32'd1);
        par_clr = 1;
        run_cycle();
        par_clr = 0;
        mem_par_err = 0;
        chk("clr_beats_int", 32'(err_cnt), 32'd0);
        idle(3);

        npi = 0;
        for (int k = 0; k < 260; k++) begin
            mem_par_err = 1; run_cycle(); npi += int'(par_int);
            mem_par_err = 0; run_cycle(); npi += int'(par_int);
        end
        run_cycle();
        chk("sat_pulses", 32'(npi), 32'd260);
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);

        wreq_b = 1; waddr_b = 4'(DEPTH); wdata_b = 32'h0BAD_0BAD;
        run_cycle();
        chk("oor_granted", 32'(last_gb), 32'd1);
        wreq_b = 0; rreq = 1; raddr = 4'd15;
        run_cycle();
        rreq = 0;
        run_cycle();
        run_cycle();
        chk("addr_err_held", 32'(addr_err), 32'd1);
        par_clr = 1;
        run_cycle();
        par_clr = 0;
        chk("addr_err_clr", 32'(addr_err), 32'd0);
        idle(2);

        for (int n = 0; n < 400; n++) begin
            if (!wreq_a || last_ga) begin
                wreq_a  = ($urandom_range(0, 2) != 0);
                waddr_a = rand_addr();
                wdata_a = $urandom;
            end
            if (!wreq_b || last_gb) begin
                wreq_b  = ($urandom_range(0, 2) != 0);
                waddr_b = rand_addr();
                wdata_b = $urandom;
            end
            rreq    = $urandom_range(0, 1);
            raddr   = rand_addr();
            par_clr = ($urandom_range(0, 19) == 0);
            run_cycle();
        end
        idle(3);

        // re-init while A waits: no grant until the sweep finishes
        init_start = 1;
        run_cycle();
        init_start = 0;
        m_run = 0;
        wreq_a = 1; waddr_a = 4'd6; wdata_a = 32'hC0DE_0006;
        wait_run(nlow);
        chk("reinit_len", 32'(nlow), 32'(DEPTH + CLR_CYC));
        for (int i = 0; i < 16; i++) m_mem[i] = INITVAL;
        m_run = 1;
        run_cycle();
        chk("reinit_a_gnt", 32'(last_ga), 32'd1);
        wreq_a = 0; rreq = 1; raddr = 4'd6;
        run_cycle();
        rreq = 0; raddr = 4'd0;
        run_cycle();
        run_cycle();
        rreq = 1; raddr = 4'd4;
        run_cycle();
        idle(3);

        wreq_a = 1; wreq_b = 1; rreq = 1; waddr_a = 4'd0; waddr_b = 4'd7; raddr = 4'd1;
        run_cycle();
        rst_ = 0;
        #1;
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_gnt", {30'd0, wgnt_a, wgnt_b}, 32'd0);
        chk("mid_rst_misc", {29'd0, init_done, rvalid, addr_err}, 32'd0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        step();
        rst_ = 1;
        rreq = 0;
        m_run = 0;
        model_reset();
        wait_run(nlow);
        chk("mid_rst_sweep", 32'(nlow), 32'(DEPTH + CLR_CYC));
        m_run = 1;
        run_cycle();
        chk("mid_rst_a_first", 32'(last_ga), 32'd1);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
